// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ARM opcode/condition codes,
// FSM encoding and the per-opcode ALU control bundles.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   typedef enum logic [1:0] {CIN_ZERO, CIN_ONE, CIN_CARRY} cin_sel_t;

   // a_from_b routes operand2 onto ALU port a (MOV/MVN); is_compare forces a flag write.
   typedef struct packed {
      logic     a_from_b;
      logic     invert_a;
      logic     invert_b;
      logic     is_logic;
      logic     func_idx;
      cin_sel_t cin_sel;
      logic     wb;
      logic     is_compare;
      logic     illegal;
   } op_ctrl_t;

   localparam op_ctrl_t CTRL_AND = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CIN_ZERO,  1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_ORR = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, CIN_ZERO,  1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_BIC = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, CIN_ZERO,  1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_MOV = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CIN_ZERO,  1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_MVN = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, CIN_ZERO,  1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_TST = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CIN_ZERO,  1'b0, 1'b1, 1'b0};
   localparam op_ctrl_t CTRL_ADD = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CIN_ZERO,  1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_ADC = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CIN_CARRY, 1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_SUB = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CIN_ONE,   1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_SBC = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CIN_CARRY, 1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_RSB = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CIN_ONE,   1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_RSC = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CIN_CARRY, 1'b1, 1'b0, 1'b0};
   localparam op_ctrl_t CTRL_CMP = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CIN_ONE,   1'b0, 1'b1, 1'b0};
   localparam op_ctrl_t CTRL_CMN = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CIN_ZERO,  1'b0, 1'b1, 1'b0};
   localparam op_ctrl_t CTRL_ILL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CIN_ZERO,  1'b0, 1'b0, 1'b1};

   function automatic op_ctrl_t decode_op(input logic [3:0] op);
      case (op)
         OP_AND:  return CTRL_AND;
         OP_ORR:  return CTRL_ORR;
         OP_BIC:  return CTRL_BIC;
         OP_MOV:  return CTRL_MOV;
         OP_MVN:  return CTRL_MVN;
         OP_TST:  return CTRL_TST;
         OP_ADD:  return CTRL_ADD;
         OP_ADC:  return CTRL_ADC;
         OP_SUB:  return CTRL_SUB;
         OP_SBC:  return CTRL_SBC;
         OP_RSB:  return CTRL_RSB;
         OP_RSC:  return CTRL_RSC;
         OP_CMP:  return CTRL_CMP;
         OP_CMN:  return CTRL_CMN;
         OP_EOR:  return CTRL_ILL;
         OP_TEQ:  return CTRL_ILL;
         default: return CTRL_ILL;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of decode-side, ALU-side and writeback-side signals of the issue controller.
interface alu_issue_ctrl_if #(parameter int WIDTH = 32);
   // Handshakes: a transfer happens on a rising edge where valid && ready; the
   // sender holds valid and its payload stable until that edge, ready may toggle freely.
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_cond;
   logic [3:0]       in_opcode;
   logic             in_s;
   logic [WIDTH-1:0] in_op_a;
   logic [WIDTH-1:0] in_op_b;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_invert_a;
   logic             alu_invert_b;
   logic             alu_is_logic;
   logic             alu_logic_func_idx;
   logic             alu_cin;
   logic [WIDTH-1:0] alu_result;
   logic             alu_n;
   logic             alu_z;
   logic             alu_c;
   logic             alu_v;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_wb;
   logic             out_skip;
   logic             out_illegal;
   logic [3:0]       nzcv;

   // slave is the controller; master is the surrounding decode/ALU/writeback logic.
   modport slave (
      input  in_valid, in_cond, in_opcode, in_s, in_op_a, in_op_b,
      input  alu_result, alu_n, alu_z, alu_c, alu_v, out_ready,
      output in_ready, alu_a, alu_b, alu_invert_a, alu_invert_b, alu_is_logic,
      output alu_logic_func_idx, alu_cin, out_valid, out_result, out_wb, out_skip,
      output out_illegal, nzcv
   );

   modport master (
      output in_valid, in_cond, in_opcode, in_s, in_op_a, in_op_b,
      output alu_result, alu_n, alu_z, alu_c, alu_v, out_ready,
      input  in_ready, alu_a, alu_b, alu_invert_a, alu_invert_b, alu_is_logic,
      input  alu_logic_func_idx, alu_cin, out_valid, out_result, out_wb, out_skip,
      input  out_illegal, nzcv
   );
endinterface

// File: rtl/alu_issue_ctrl_cond_eval.sv
// ARM condition-field evaluation against NZCV; shared with the branch unit.
module cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_nzcv,
   output logic       o_pass
);
   logic w_n, w_z, w_c, w_v;

   assign {w_n, w_z, w_c, w_v} = i_nzcv;

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         COND_EQ: o_pass = w_z;
         COND_NE: o_pass = !w_z;
         COND_CS: o_pass = w_c;
         COND_CC: o_pass = !w_c;
         COND_MI: o_pass = w_n;
         COND_PL: o_pass = !w_n;
         COND_VS: o_pass = w_v;
         COND_VC: o_pass = !w_v;
         COND_HI: o_pass = w_c && !w_z;
         COND_LS: o_pass = !w_c || w_z;
         COND_GE: o_pass = (w_n == w_v);
         COND_LT: o_pass = (w_n != w_v);
         COND_GT: o_pass = !w_z && (w_n == w_v);
         COND_LE: o_pass = w_z || (w_n != w_v);
         COND_AL: o_pass = 1'b1;
         COND_NV: o_pass = 1'b0;
         default: o_pass = 1'b0;
      endcase
   end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side ALU controller: accepts one data-processing op, drives the ALU for a
// fixed settle window, captures the result and owns the architectural NZCV flags.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int ALU_LAT = 2,
   parameter int WIDTH   = 32
) (
   input  logic            clk,
   input  logic            rst,
   alu_issue_ctrl_if.slave bus,
   output state_t          o_dbg_state
);
   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   state_t           r_state;
   logic [3:0]       r_cnt;
   op_ctrl_t         r_op;
   logic             r_s;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_cin;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   logic             r_out_wb;
   logic             r_out_skip;
   logic             r_out_illegal;
   logic [3:0]       r_nzcv;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic             r_alu_inv_a;
   logic             r_alu_inv_b;
   logic             r_alu_is_logic;
   logic             r_alu_func;
   logic             r_alu_cin;

   logic             w_pass;
   op_ctrl_t         w_dec;

   cond_eval u_cond_eval (
      .i_cond (bus.in_cond),
      .i_nzcv (r_nzcv),
      .o_pass (w_pass)
   );

   assign w_dec = decode_op(bus.in_opcode);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_op           <= '0;
         r_s            <= 1'b0;
         r_a            <= '0;
         r_b            <= '0;
         r_cin          <= 1'b0;
         r_in_ready     <= 1'b1;
         r_out_valid    <= 1'b0;
         r_out_result   <= '0;
         r_out_wb       <= 1'b0;
         r_out_skip     <= 1'b0;
         r_out_illegal  <= 1'b0;
         r_nzcv         <= 4'b0000;
         r_alu_a        <= '0;
         r_alu_b        <= '0;
         r_alu_inv_a    <= 1'b0;
         r_alu_inv_b    <= 1'b0;
         r_alu_is_logic <= 1'b0;
         r_alu_func     <= 1'b0;
         r_alu_cin      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_op       <= w_dec;
                  r_s        <= bus.in_s;
                  r_a        <= bus.in_op_a;
                  r_b        <= bus.in_op_b;
                  r_cin      <= r_nzcv[1];
                  r_in_ready <= 1'b0;
                  // Failed condition takes priority over an illegal opcode; neither touches the ALU.
                  if (!w_pass || w_dec.illegal) begin
                     r_state       <= ST_DONE;
                     r_out_valid   <= 1'b1;
                     r_out_result  <= '0;
                     r_out_wb      <= 1'b0;
                     r_out_skip    <= !w_pass;
                     r_out_illegal <= w_pass;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               r_alu_a        <= r_op.a_from_b ? r_b : r_a;
               r_alu_b        <= r_b;
               r_alu_inv_a    <= r_op.invert_a;
               r_alu_inv_b    <= r_op.invert_b;
               r_alu_is_logic <= r_op.is_logic;
               r_alu_func     <= r_op.func_idx;
               case (r_op.cin_sel)
                  CIN_ONE:   r_alu_cin <= 1'b1;
                  CIN_CARRY: r_alu_cin <= r_cin;
                  default:   r_alu_cin <= 1'b0;
               endcase
               r_cnt   <= LAT_M1;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state       <= ST_DONE;
                  r_out_valid   <= 1'b1;
                  r_out_result  <= bus.alu_result;
                  r_out_wb      <= r_op.wb;
                  r_out_skip    <= 1'b0;
                  r_out_illegal <= r_op.illegal;
                  // Logic ops have no meaningful carry/overflow, so C and V are preserved.
                  if (r_s || r_op.is_compare) begin
                     if (r_op.is_logic)
                        r_nzcv <= {bus.alu_n, bus.alu_z, r_nzcv[1:0]};
                     else
                        r_nzcv <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_state       <= ST_IDLE;
                  r_out_valid   <= 1'b0;
                  r_out_wb      <= 1'b0;
                  r_out_skip    <= 1'b0;
                  r_out_illegal <= 1'b0;
                  r_in_ready    <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready           = r_in_ready;
   assign bus.alu_a              = r_alu_a;
   assign bus.alu_b              = r_alu_b;
   assign bus.alu_invert_a       = r_alu_inv_a;
   assign bus.alu_invert_b       = r_alu_inv_b;
   assign bus.alu_is_logic       = r_alu_is_logic;
   assign bus.alu_logic_func_idx = r_alu_func;
   assign bus.alu_cin            = r_alu_cin;
   assign bus.out_valid          = r_out_valid;
   assign bus.out_result         = r_out_result;
   assign bus.out_wb             = r_out_wb;
   assign bus.out_skip           = r_out_skip;
   assign bus.out_illegal        = r_out_illegal;
   assign bus.nzcv               = r_nzcv;
   assign o_dbg_state            = r_state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a settle-aware ALU model, an ARM reference model feeding
// an expected-results queue, and directed plus random scenarios.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int ALU_LAT = 2;

   logic   clk = 1'b0;
   logic   rst;
   state_t dbg_state;
   int     checks = 0;
   int     failures = 0;
   logic [3:0]  m_nzcv;
   // {result[38:7], nzcv[6:3], wb[2], skip[1], illegal[0]}
   logic [38:0] exp_q[$];

   alu_issue_ctrl_if #(.WIDTH(32)) bus();

   alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // ALU model: outputs are corrupted until inputs have been stable for ALU_LAT cycles.
   logic [31:0] m_a, m_b, m_res;
   logic [32:0] m_sum;
   logic [68:0] alu_now;
   logic [68:0] alu_snap = '1;
   int          stable = 0;
   logic        settled;
   logic        m_c, m_v;

   always_comb begin
      m_a   = bus.alu_invert_a ? ~bus.alu_a : bus.alu_a;
      m_b   = bus.alu_invert_b ? ~bus.alu_b : bus.alu_b;
      m_sum = {1'b0, m_a} + {1'b0, m_b} + {32'b0, bus.alu_cin};
      if (bus.alu_is_logic) m_res = bus.alu_logic_func_idx ? (m_a | m_b) : (m_a & m_b);
      else                  m_res = m_sum[31:0];
      m_c = bus.alu_is_logic ? 1'b0 : m_sum[32];
      m_v = bus.alu_is_logic ? 1'b0 : ((m_a[31] == m_b[31]) && (m_res[31] != m_a[31]));
   end

   assign alu_now = {bus.alu_a, bus.alu_b, bus.alu_invert_a, bus.alu_invert_b,
                     bus.alu_is_logic, bus.alu_logic_func_idx, bus.alu_cin};
   assign settled = (stable >= ALU_LAT);

   always @(negedge clk) begin
      if (alu_now !== alu_snap) begin
         alu_snap <= alu_now;
         stable   <= 1;
      end else if (stable < 15) begin
         stable <= stable + 1;
      end
   end

   assign bus.alu_result = settled ? m_res : ~m_res;
   assign bus.alu_n      = settled ? m_res[31] : ~m_res[31];
   assign bus.alu_z      = settled ? (m_res == 32'h0) : (m_res != 32'h0);
   assign bus.alu_c      = settled ? m_c : ~m_c;
   assign bus.alu_v      = settled ? m_v : ~m_v;

   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // ARM semantics computed with wide integer arithmetic.
   function automatic logic [38:0] ref_op(input logic [3:0] cond, input logic [3:0] op,
                                          input logic s, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] f);
      longint smax, smin, sa, sb, sr, ua, ub, ur, nc;
      logic [31:0] r;
      logic        arith, cmp, c, v;
      logic [3:0]  nf;
      smax = 64'sd2147483647;
      smin = -smax - 64'sd1;
      if (!cond_ok(cond, f)) return {32'h0, f, 3'b010};
      if (op == 4'h1 || op == 4'h9) return {32'h0, f, 3'b001};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      nc = f[1] ? 64'sd0 : 64'sd1;
      arith = 1'b1;
      c = f[1];
      v = f[0];
      ur = 0;
      sr = 0;
      r  = 32'h0;
      case (op)
         4'h4, 4'hB: begin ur = ua + ub;       sr = sa + sb;       c = (ur >>> 32) != 0; end
         4'h5:       begin ur = ua + ub + 1 - nc; sr = sa + sb + 1 - nc; c = (ur >>> 32) != 0; end
         4'h2, 4'hA: begin ur = ua - ub;       sr = sa - sb;       c = ua >= ub; end
         4'h6:       begin ur = ua - ub - nc;  sr = sa - sb - nc;  c = ua >= ub + nc; end
         4'h3:       begin ur = ub - ua;       sr = sb - sa;       c = ub >= ua; end
         4'h7:       begin ur = ub - ua - nc;  sr = sb - sa - nc;  c = ub >= ua + nc; end
         4'h0, 4'h8: begin arith = 1'b0; r = a & b;  end
         4'hC:       begin arith = 1'b0; r = a | b;  end
         4'hD:       begin arith = 1'b0; r = b;      end
         4'hE:       begin arith = 1'b0; r = a & ~b; end
         default:    begin arith = 1'b0; r = ~b;     end
      endcase
      if (arith) begin
         r = ur[31:0];
         v = (sr > smax) || (sr < smin);
      end
      cmp = (op == 4'h8) || (op == 4'hA) || (op == 4'hB);
      nf  = (s || cmp) ? {r[31], r == 32'h0, c, v} : f;
      return {r, nf, !cmp, 2'b00};
   endfunction

   task automatic send_op(input logic [3:0] cond, input logic [3:0] op, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
      int          guard;
      logic [38:0] e;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
      end
      e = ref_op(cond, op, s, a, b, m_nzcv);
      exp_q.push_back(e);
      m_nzcv        = e[6:3];
      bus.in_valid  = 1'b1;
      bus.in_cond   = cond;
      bus.in_opcode = op;
      bus.in_s      = s;
      bus.in_op_a   = a;
      bus.in_op_b   = b;
      @(negedge clk);
      bus.in_valid  = 1'b0;
   endtask

   task automatic wait_out(input int start, output int lat);
      lat = start;
      while (!bus.out_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL out_valid_timeout out_valid=%b required=1", bus.out_valid);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE); end
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      checks++;
      if ({bus.out_wb, bus.out_skip, bus.out_illegal} !== 3'b000) begin
         failures++;
         $display("FAIL reset_out_flags got=%b want=000", {bus.out_wb, bus.out_skip, bus.out_illegal});
      end
      checks++;
      if (bus.out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%h want=0", bus.out_result); end
      checks++;
      if (bus.nzcv !== 4'b0000) begin failures++; $display("FAIL reset_nzcv got=%b want=0000", bus.nzcv); end
      checks++;
      if (alu_now !== 69'h0) begin failures++; $display("FAIL reset_alu_ctrl got=%h want=0", alu_now); end
   endtask

   task automatic test_adds();
      int          lat;
      logic [38:0] e;
      send_op(COND_AL, OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
      wait_out(1, lat);
      e = exp_q.pop_front();
      checks++;
      if (lat != ALU_LAT + 2) begin failures++; $display("FAIL adds_latency got=%0d want=%0d", lat, ALU_LAT + 2); end
      checks++;
      if (bus.out_result !== e[38:7]) begin failures++; $display("FAIL adds_result got=%h want=%h", bus.out_result, e[38:7]); end
      checks++;
      if (bus.nzcv !== e[6:3]) begin failures++; $display("FAIL adds_nzcv got=%b want=%b", bus.nzcv, e[6:3]); end
      checks++;
      if ({bus.out_wb, bus.out_skip, bus.out_illegal} !== e[2:0]) begin
         failures++;
         $display("FAIL adds_flags got=%b want=%b", {bus.out_wb, bus.out_skip, bus.out_illegal}, e[2:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_cmp();
      int          lat;
      logic [38:0] e;
      send_op(COND_AL, OP_CMP, 1'b0, 32'd5, 32'd5);
      @(negedge clk);
      checks++;
      if ({bus.alu_invert_a, bus.alu_invert_b, bus.alu_is_logic, bus.alu_cin} !== 4'b0101) begin
         failures++;
         $display("FAIL cmp_alu_ctrl got=%b want=0101",
                  {bus.alu_invert_a, bus.alu_invert_b, bus.alu_is_logic, bus.alu_cin});
      end
      wait_out(2, lat);
      e = exp_q.pop_front();
      checks++;
      if (bus.out_result !== e[38:7]) begin failures++; $display("FAIL cmp_result got=%h want=%h", bus.out_result, e[38:7]); end
      checks++;
      if (bus.nzcv !== e[6:3]) begin failures++; $display("FAIL cmp_nzcv got=%b want=%b", bus.nzcv, e[6:3]); end
      checks++;
      if (bus.out_wb !== e[2]) begin failures++; $display("FAIL cmp_wb got=%b want=%b", bus.out_wb, e[2]); end
      @(negedge clk);
   endtask

   task automatic test_skip();
      int          lat;
      logic [38:0] e;
      send_op(COND_NE, OP_ADD, 1'b1, 32'd1, 32'd2);
      wait_out(1, lat);
      e = exp_q.pop_front();
      checks++;
      if (lat != 1) begin failures++; $display("FAIL skip_latency got=%0d want=1", lat); end
      checks++;
      if ({bus.out_wb, bus.out_skip, bus.out_illegal} !== e[2:0]) begin
         failures++;
         $display("FAIL skip_flags got=%b want=%b", {bus.out_wb, bus.out_skip, bus.out_illegal}, e[2:0]);
      end
      checks++;
      if (bus.nzcv !== e[6:3]) begin failures++; $display("FAIL skip_nzcv got=%b want=%b", bus.nzcv, e[6:3]); end
      checks++;
      if (alu_now !== {32'd5, 32'd5, 5'b01001}) begin
         failures++;
         $display("FAIL skip_alu_ctrl got=%h want=%h", alu_now, {32'd5, 32'd5, 5'b01001});
      end
      @(negedge clk);
   endtask

   task automatic test_bics();
      int          lat;
      logic [38:0] e;
      send_op(COND_AL, OP_ADD, 1'b1, 32'h8000_0000, 32'h8000_0000);
      wait_out(1, lat);
      e = exp_q.pop_front();
      checks++;
      if (bus.nzcv !== e[6:3]) begin failures++; $display("FAIL bics_setup_nzcv got=%b want=%b", bus.nzcv, e[6:3]); end
      @(negedge clk);
      send_op(COND_AL, OP_BIC, 1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F);
      wait_out(1, lat);
      e = exp_q.pop_front();
      checks++;
      if (bus.out_result !== e[38:7]) begin failures++; $display("FAIL bics_result got=%h want=%h", bus.out_result, e[38:7]); end
      checks++;
      if (bus.nzcv !== e[6:3]) begin failures++; $display("FAIL bics_nzcv got=%b want=%b", bus.nzcv, e[6:3]); end
      @(negedge clk);
   endtask

   task automatic test_illegal();
      int          lat;
      logic [38:0] e;
      bus.out_ready = 1'b0;
      send_op(COND_AL, OP_EOR, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F);
      wait_out(1, lat);
      e = exp_q.pop_front();
      checks++;
      if (lat != 1) begin failures++; $display("FAIL illegal_latency got=%0d want=1", lat); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.out_valid, bus.out_wb, bus.out_skip, bus.out_illegal, bus.in_ready} !== {1'b1, e[2:0], 1'b0}) begin
            failures++;
            $display("FAIL illegal_hold cycle=%0d got=%b want=%b", i,
                     {bus.out_valid, bus.out_wb, bus.out_skip, bus.out_illegal, bus.in_ready}, {1'b1, e[2:0], 1'b0});
         end
         checks++;
         if (bus.nzcv !== m_nzcv) begin failures++; $display("FAIL illegal_nzcv got=%b want=%b", bus.nzcv, m_nzcv); end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         failures++;
         $display("FAIL illegal_release got=%b want=01", {bus.out_valid, bus.in_ready});
      end
   endtask

   task automatic test_reset_in_wait();
      send_op(COND_AL, OP_ADD, 1'b1, 32'd1, 32'd1);
      @(negedge clk);
      checks++;
      if (dbg_state !== ST_WAIT) begin failures++; $display("FAIL rstwait_pre_state got=%0d want=%0d", dbg_state, ST_WAIT); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({dbg_state, bus.out_valid, bus.nzcv, bus.in_ready} !== {ST_IDLE, 1'b0, 4'b0000, 1'b1}) begin
         failures++;
         $display("FAIL rstwait_state got=%b want=%b", {dbg_state, bus.out_valid, bus.nzcv, bus.in_ready},
                  {ST_IDLE, 1'b0, 4'b0000, 1'b1});
      end
      rst = 1'b0;
      exp_q.delete();
      m_nzcv = 4'b0000;
      for (int i = 0; i < ALU_LAT + 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstwait_no_valid got=%b want=0", bus.out_valid); end
      end
   endtask

   task automatic test_back_to_back(input int n);
      int          lat, hold;
      logic [38:0] e;
      logic [31:0] a, b;
      logic [3:0]  cond, op;
      for (int k = 0; k < n; k++) begin
         cond = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) cond = COND_AL;
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: a = 32'h7FFF_FFFF;
            1: b = 32'h8000_0000;
            2: b = a;
            default: ;
         endcase
         hold = $urandom_range(0, 2);
         bus.out_ready = 1'b0;
         send_op(cond, op, 1'($urandom_range(0, 1)), a, b);
         wait_out(1, lat);
         e = exp_q.pop_front();
         checks++;
         if (lat != ((e[1] || e[0]) ? 1 : ALU_LAT + 2)) begin
            failures++;
            $display("FAIL rand_latency op=%h cond=%h got=%0d", op, cond, lat);
         end
         if (!(e[1] || e[0])) begin
            checks++;
            if (bus.out_result !== e[38:7]) begin
               failures++;
               $display("FAIL rand_result op=%h a=%h b=%h got=%h want=%h", op, a, b, bus.out_result, e[38:7]);
            end
         end
         checks++;
         if (bus.nzcv !== e[6:3]) begin
            failures++;
            $display("FAIL rand_nzcv op=%h cond=%h a=%h b=%h got=%b want=%b", op, cond, a, b, bus.nzcv, e[6:3]);
         end
         checks++;
         if ({bus.out_wb, bus.out_skip, bus.out_illegal} !== e[2:0]) begin
            failures++;
            $display("FAIL rand_flags op=%h cond=%h got=%b want=%b", op, cond,
                     {bus.out_wb, bus.out_skip, bus.out_illegal}, e[2:0]);
         end
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rand_hold got=%b want=1", bus.out_valid); end
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_cond   = 4'h0;
      bus.in_opcode = 4'h0;
      bus.in_s      = 1'b0;
      bus.in_op_a   = 32'h0;
      bus.in_op_b   = 32'h0;
      bus.out_ready = 1'b1;
      m_nzcv        = 4'b0000;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_adds();
      test_cmp();
      test_skip();
      test_bics();
      test_illegal();
      test_reset_in_wait();
      test_back_to_back(60);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Drives the 32-bit ALU from the issue side.
- Accepts one ARM data-processing micro-op per handshake and checks its condition field against the architectural NZCV flags.
- Translates the opcode into the ALU control lines, waits a fixed settle window, then captures the ALU result and flags.
- Updates NZCV when S is set and returns the result to writeback.
- Sits between the decode stage and the ALU, and owns the CPSR flag bits.

Parameters:
- ALU_LAT, 2, cycles the ALU outputs need to settle after the controls/operands are registered (1..15).
- WIDTH, 32, datapath width; fixed at 32 for this core.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  micro-op present.
- in_ready  out  1  controller can accept.
- in_cond  in  4  ARM condition field.
- in_opcode  in  4  ARM data-processing opcode.
- in_s  in  1  set-flags bit.
- in_op_a  in  32  Rn value.
- in_op_b  in  32  shifted operand2.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- alu_invert_a  out  1  ALU control.
- alu_invert_b  out  1  ALU control.
- alu_is_logic  out  1  ALU control.
- alu_logic_func_idx  out  1  ALU control: 0 = AND, 1 = OR.
- alu_cin  out  1  ALU carry-in.
- alu_result  in  32  ALU result.
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts.
- out_result  out  32  captured result.
- out_wb  out  1  result must be written to Rd.
- out_skip  out  1  condition failed; no architectural effect.
- out_illegal  out  1  opcode unsupported (EOR/TEQ).
- nzcv  out  4  architectural flags {N,Z,C,V}.

Behaviour:
- Reset (synchronous, active-high; "Already decided": one clock, synchronous active-high reset on rst, clock clk) values:
  - state = IDLE.
  - in_ready = 1.
  - out_valid, out_wb, out_skip, out_illegal = 0.
  - out_result = 0, nzcv = 0.
  - All alu_* outputs = 0.
- Reset asserted in any state aborts the op: no flag update, no out_valid.
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  - IDLE: in_ready = 1. On in_valid, latch the op and evaluate the condition against the current nzcv.
    - Condition fail, or cond = 1111 (NV treated as never): go directly to DONE with out_skip = 1.
    - Illegal opcode: go directly to DONE with out_illegal = 1.
    - Otherwise go to ISSUE.
  - ISSUE: register the alu_* controls and operands. 1 cycle.
  - WAIT: count down ALU_LAT cycles with controls held stable.
    - On the last cycle, capture alu_result and the flags.
    - If S = 1 or the op is TST/CMP/CMN, write nzcv.
  - DONE: out_valid = 1, outputs held until out_ready. Returns to IDLE on the out_valid && out_ready cycle; in_ready = 0 in all states except IDLE.
- Latency:
  - Executed op: out_valid first high ALU_LAT+2 cycles after the accept edge.
  - Skipped or illegal op: 1 cycle after the accept edge.
- Conditions:
  - EQ: Z. NE: !Z. CS: C. CC: !C. MI: N. PL: !N. VS: V. VC: !V.
  - HI: C&!Z. LS: !C|Z.
  - GE: N==V. LT: N!=V. GT: !Z&(N==V). LE: Z|(N!=V).
  - AL: 1. NV: 0.
- Opcode map. In the a/b/ia/ib/logic/func/cin columns, A = Rn and B = operand2.
  - AND: A, B, 0, 0, 1, 0, -
  - ORR: A, B, 0, 0, 1, 1, -
  - BIC: A, B, 0, 1, 1, 0, -
  - MOV: B, B, 0, 0, 1, 1, -
  - MVN: B, B, 1, 1, 1, 0, -
  - TST: as AND, no writeback.
  - ADD: A, B, 0, 0, 0, -, 0
  - ADC: A, B, 0, 0, 0, -, C
  - SUB: A, B, 0, 1, 0, -, 1
  - SBC: A, B, 0, 1, 0, -, C
  - RSB: A, B, 1, 0, 0, -, 1
  - RSC: A, B, 1, 0, 0, -, C
  - CMP: as SUB, no writeback.
  - CMN: as ADD, no writeback.
  - EOR, TEQ: illegal.
  - C used by ADC/SBC/RSC is nzcv[1] sampled at accept.
- out_wb = 1 for every executed op except TST/CMP/CMN.
- Flag update:
  - Arithmetic ops: all four flags from the ALU.
  - Logic ops: N and Z from the ALU; C and V unchanged.
- A skipped op never changes nzcv.
- The same op presented back-to-back is accepted only after the prior DONE handshake.

Decomposition:
- Shared package alu_pkg:
  - opcode constants (OP_AND..OP_MVN).
  - condition constants (COND_EQ..COND_NV).
  - state encoding.
  - ALU control bundle constants.
- One natural sub-module: cond_eval (combinational, in_cond + nzcv -> pass). Reusable by the branch unit.

Test Plan:
- nzcv = 0; ADDS with A = 0x7FFFFFFF, B = 1, AL -> out_result = 0x80000000, nzcv = 1001, out_wb = 1, out_valid at accept+ALU_LAT+2.
- CMP with A = 5, B = 5 -> alu_invert_b = 1, alu_cin = 1, out_result = 0, out_wb = 0, nzcv = 0110.
- With Z = 1, ADDNE A = 1, B = 2 -> out_skip = 1 one cycle after accept; nzcv unchanged; no ALU controls change.
- BICS with A = 0xFF00FF00, B = 0x0F0F0F0F, prior C = 1, V = 1 -> result 0xF000F000, nzcv = 1011.
- EOR opcode -> out_illegal = 1, out_wb = 0, nzcv unchanged. Hold out_ready = 0 for 3 cycles: outputs stable and in_ready = 0 throughout.
- Assert rst during WAIT of an ADDS -> next cycle state IDLE, out_valid = 0, nzcv = 0000, in_ready = 1.
